// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute unit: op-class and funct encodings,
// 3-bit control codes, the control FSM state type and the main decoder.
package alu_exec_pkg;

    // Main-decoder op classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    // R-type function field encodings
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Decoded control codes
    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       illegal;
    } decode_t;

    // Op class + funct -> control code; unknown funct falls back to add.
    function automatic decode_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        decode_t dec;
        dec.ctrl    = CTRL_ADD;
        dec.illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: dec.ctrl = CTRL_ADD;
            ALUOP_SUB: dec.ctrl = CTRL_SUB;
            ALUOP_OR:  dec.ctrl = CTRL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: dec.ctrl = CTRL_ADD;
                    FUNCT_SUB: dec.ctrl = CTRL_SUB;
                    FUNCT_OR:  dec.ctrl = CTRL_OR;
                    FUNCT_AND: dec.ctrl = CTRL_AND;
                    FUNCT_MUL: dec.ctrl = CTRL_MUL;
                    FUNCT_SLT: dec.ctrl = CTRL_SLT;
                    default: begin
                        dec.ctrl    = CTRL_ADD;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            default: dec.ctrl = CTRL_ADD;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for DATA_W
// cycles; product_o carries the low DATA_W bits of the product, including the
// current iteration's partial sum, so the last iteration's result is usable
// in the same cycle done_o is high. Built only with ALU_EXEC_MUL_EN.
module alu_exec_mul
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int unsigned     CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_next_s;

    assign acc_next_s = busy_q ? (acc_q + (b_q[0] ? a_q : {DATA_W{1'b0}})) : acc_q;
    assign done_o     = busy_q && (cnt_q == LAST_ITER);
    assign product_o  = acc_next_s;

    // Iteration control: clear beats start, start beats stepping.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        if (clear_i) begin
            busy_d = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
            a_d    = {DATA_W{1'b0}};
            b_d    = {DATA_W{1'b0}};
            acc_d  = {DATA_W{1'b0}};
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = {DATA_W{1'b0}};
        end else if (busy_q) begin
            acc_d = acc_next_s;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            a_q    <= {DATA_W{1'b0}};
            b_q    <= {DATA_W{1'b0}};
            acc_q  <= {DATA_W{1'b0}};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit with valid/ready handshakes on both sides and a one-entry
// registered output slot. Single-cycle add/sub/or/and/slt; multiply is an
// iterative shift-add sequence enabled by the ALU_EXEC_MUL_EN macro. Without
// the macro, funct 011000 completes in one cycle as an illegal op with result 0.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic [2:0]        ctrl_o,
    output logic              illegal_o
);

    // Elaboration-time guard on the legal parameter range.
    if (DATA_W < 8 || DATA_W > 64 || CNT_W != $clog2(DATA_W) + 1) begin : g_param_check
        $error("alu_exec_unit: illegal DATA_W/CNT_W");
    end

    // Single-cycle datapath; mul and unknown codes yield zero here.
    function automatic logic [DATA_W-1:0] alu_compute(input logic [2:0] ctrl,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        case (ctrl)
            CTRL_ADD: res = a + b;
            CTRL_SUB: res = a - b;
            CTRL_OR:  res = a | b;
            CTRL_AND: res = a & b;
            CTRL_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;

    decode_t           dec_s;
    logic              op_illegal_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              out_free_s;
    logic              accept_s;

    assign dec_s        = alu_decode(ALUOp_i, funct_i);
    assign alu_result_s = alu_compute(dec_s.ctrl, src_a_i, src_b_i);
    assign out_free_s   = !valid_q || ready_i;
    assign ready_o      = rst_n_i && (state_q == ST_IDLE) && out_free_s && !flush_i;
    assign accept_s     = valid_i && ready_o;

`ifdef ALU_EXEC_MUL_EN
    logic              op_is_mul_s;
    logic              mul_start_s;
    logic              mul_done_s;
    logic [DATA_W-1:0] mul_product_s;

    assign op_illegal_s = dec_s.illegal;
    assign op_is_mul_s  = (dec_s.ctrl == CTRL_MUL);

    alu_exec_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (flush_i),
        .start_i   (mul_start_s),
        .a_i       (src_a_i),
        .b_i       (src_b_i),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );
`else
    assign op_illegal_s = dec_s.illegal || (dec_s.ctrl == CTRL_MUL);
`endif

    // Control FSM and output-slot next state; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q && !ready_i;
        result_d  = result_q;
        zero_d    = zero_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        mul_start_s = 1'b0;
`endif
        if (flush_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
`ifdef ALU_EXEC_MUL_EN
                        if (op_is_mul_s) begin
                            mul_start_s = 1'b1;
                            state_d     = ST_MUL;
                        end else begin
                            result_d  = alu_result_s;
                            zero_d    = (alu_result_s == {DATA_W{1'b0}});
                            ctrl_d    = dec_s.ctrl;
                            illegal_d = op_illegal_s;
                            valid_d   = 1'b1;
                        end
`else
                        result_d  = alu_result_s;
                        zero_d    = (alu_result_s == {DATA_W{1'b0}});
                        ctrl_d    = dec_s.ctrl;
                        illegal_d = op_illegal_s;
                        valid_d   = 1'b1;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                ST_MUL: begin
                    if (mul_done_s) begin
                        if (out_free_s) begin
                            result_d  = mul_product_s;
                            zero_d    = (mul_product_s == {DATA_W{1'b0}});
                            ctrl_d    = CTRL_MUL;
                            illegal_d = 1'b0;
                            valid_d   = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                ST_WAIT: begin
                    if (out_free_s) begin
                        result_d  = mul_product_s;
                        zero_d    = (mul_product_s == {DATA_W{1'b0}});
                        ctrl_d    = CTRL_MUL;
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output-slot registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            result_q  <= {DATA_W{1'b0}};
            zero_q    <= 1'b0;
            ctrl_q    <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign ctrl_o    = ctrl_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (DATA_W=32). Mul scenarios are built
// only when ALU_EXEC_MUL_EN is defined; otherwise the one-cycle illegal-mul
// behaviour is checked.
module tb_alu_exec_unit;

    localparam int DW = 32;

    logic          clk_i, rst_n_i, valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [1:0]    ALUOp_i;
    logic [5:0]    funct_i;
    logic [DW-1:0] src_a_i, src_b_i, result_o;
    logic          zero_o, illegal_o;
    logic [2:0]    ctrl_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]    op;
        logic [5:0]    fn;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic [2:0]    ctrl;
        logic          ill;
    } vec_t;

    alu_exec_unit #(.DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .zero_o(zero_o), .ctrl_o(ctrl_o), .illegal_o(illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural reference: what each op class / funct means arithmetically.
    function automatic void ref_op(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output logic [DW-1:0] res, output logic [2:0] ctrl,
                                   output logic ill);
        ill = 1'b0;
        if (op == 2'd0) begin res = a + b; ctrl = 3'b010; end
        else if (op == 2'd1) begin res = a - b; ctrl = 3'b110; end
        else if (op == 2'd2) begin res = a | b; ctrl = 3'b001; end
        else begin
            case (fn)
                6'h20: begin res = a + b; ctrl = 3'b010; end
                6'h22: begin res = a - b; ctrl = 3'b110; end
                6'h25: begin res = a | b; ctrl = 3'b001; end
                6'h24: begin res = a & b; ctrl = 3'b000; end
                6'h2a: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ctrl = 3'b111; end
`ifdef ALU_EXEC_MUL_EN
                6'h18: begin res = a * b; ctrl = 3'b011; end
`else
                6'h18: begin res = 32'd0; ctrl = 3'b011; ill = 1'b1; end
`endif
                default: begin res = a + b; ctrl = 3'b010; ill = 1'b1; end
            endcase
        end
    endfunction

    task automatic idle_inputs;
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        ALUOp_i = 2'd0; funct_i = 6'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        idle_inputs();
        valid_i = 1'b1; src_a_i = 32'd5; src_b_i = 32'd6;
        repeat (3) tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero_o); end
        checks++; if (ctrl_o !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", ctrl_o); end
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        rst_n_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", ready_o); end
        tick();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || result_o !== 32'd11) begin
            errors++; $display("FAIL first_accept: got v=%b r=%h want v=1 r=0000000b", valid_o, result_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL first_drain: got %b want 0", valid_o); end
    endtask

    task automatic test_directed;
        vec_t vecs[$];
        logic exp_zero;
        vecs.push_back({2'd3, 6'h20, 32'hFFFFFFFF, 32'd1, 32'd0, 3'b010, 1'b0});
        vecs.push_back({2'd3, 6'h2a, 32'hFFFFFFFE, 32'd3, 32'd1, 3'b111, 1'b0});
        vecs.push_back({2'd3, 6'h2a, 32'd3, 32'hFFFFFFFE, 32'd0, 3'b111, 1'b0});
        vecs.push_back({2'd3, 6'h3f, 32'd5, 32'd7, 32'd12, 3'b010, 1'b1});
        vecs.push_back({2'd0, 6'h00, 32'd10, 32'd20, 32'd30, 3'b010, 1'b0});
        vecs.push_back({2'd1, 6'h24, 32'd5, 32'd7, 32'hFFFFFFFE, 3'b110, 1'b0});
        vecs.push_back({2'd2, 6'h00, 32'h000000F0, 32'h0000000F, 32'h000000FF, 3'b001, 1'b0});
        vecs.push_back({2'd3, 6'h24, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 3'b000, 1'b0});
        vecs.push_back({2'd3, 6'h22, 32'd9, 32'd9, 32'd0, 3'b110, 1'b0});
        vecs.push_back({2'd3, 6'h25, 32'h80000000, 32'd1, 32'h80000001, 3'b001, 1'b0});
        vecs.push_back({2'd3, 6'h2a, 32'h7FFFFFFF, 32'h80000000, 32'd0, 3'b111, 1'b0});
`ifndef ALU_EXEC_MUL_EN
        vecs.push_back({2'd3, 6'h18, 32'd7, 32'd6, 32'd0, 3'b011, 1'b1});
`endif
        idle_inputs();
        foreach (vecs[i]) begin
            valid_i = 1'b1; ALUOp_i = vecs[i].op; funct_i = vecs[i].fn;
            src_a_i = vecs[i].a; src_b_i = vecs[i].b;
            #1;
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL dir_ready[%0d]: got %b want 1", i, ready_o); end
            tick();
            valid_i = 1'b0;
            exp_zero = (vecs[i].res == 32'd0);
            checks++;
            if (valid_o !== 1'b1 || result_o !== vecs[i].res || zero_o !== exp_zero ||
                ctrl_o !== vecs[i].ctrl || illegal_o !== vecs[i].ill) begin
                errors++;
                $display("FAIL dir_vec[%0d]: got v=%b r=%h z=%b c=%b i=%b want v=1 r=%h z=%b c=%b i=%b",
                         i, valid_o, result_o, zero_o, ctrl_o, illegal_o,
                         vecs[i].res, exp_zero, vecs[i].ctrl, vecs[i].ill);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        idle_inputs();
        ready_i = 1'b0; valid_i = 1'b1; ALUOp_i = 2'd0; src_a_i = 32'd1; src_b_i = 32'd2;
        tick();
        ALUOp_i = 2'd1; src_a_i = 32'd100; src_b_i = 32'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", k, ready_o); end
            checks++; if (valid_o !== 1'b1 || result_o !== 32'd3 || ctrl_o !== 3'b010) begin
                errors++; $display("FAIL hold_stable[%0d]: got v=%b r=%h c=%b want v=1 r=3 c=010", k, valid_o, result_o, ctrl_o); end
            tick();
        end
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || result_o !== 32'd99 || ctrl_o !== 3'b110) begin
            errors++; $display("FAIL b2b_replace: got v=%b r=%h c=%b want v=1 r=63 c=110", valid_o, result_o, ctrl_o); end
        ALUOp_i = 2'd2; src_a_i = 32'h0000000C; src_b_i = 32'h00000003;
        tick();
        checks++; if (valid_o !== 1'b1 || result_o !== 32'h0000000F) begin
            errors++; $display("FAIL b2b_second: got v=%b r=%h want v=1 r=f", valid_o, result_o); end
        valid_i = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", valid_o); end
    endtask

    task automatic test_random;
        logic [5:0]    fn_pool[7];
        logic          exp_valid, exp_ready, exp_ill, exp_zero;
        logic [DW-1:0] exp_res, r_res;
        logic [2:0]    exp_ctrl, r_ctrl;
        logic          r_ill;
        fn_pool = '{6'h20, 6'h22, 6'h25, 6'h24, 6'h18, 6'h2a, 6'h00};
        idle_inputs();
        exp_valid = 1'b0; exp_res = '0; exp_ctrl = '0; exp_ill = 1'b0;
        for (int n = 0; n < 300; n++) begin
            exp_zero = (exp_res == 32'd0);
            checks++; if (valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, valid_o, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (result_o !== exp_res || zero_o !== exp_zero || ctrl_o !== exp_ctrl || illegal_o !== exp_ill) begin
                    errors++;
                    $display("FAIL rnd_out[%0d]: got r=%h z=%b c=%b i=%b want r=%h z=%b c=%b i=%b",
                             n, result_o, zero_o, ctrl_o, illegal_o, exp_res, exp_zero, exp_ctrl, exp_ill);
                end
            end
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            ALUOp_i = 2'($urandom_range(0, 3));
            funct_i = fn_pool[$urandom_range(0, 6)];
            if (funct_i == 6'h00) funct_i = 6'($urandom);
`ifdef ALU_EXEC_MUL_EN
            if (funct_i == 6'h18) funct_i = 6'h20;
`endif
            src_a_i = $urandom;
            case ($urandom_range(0, 3))
                0: src_b_i = $urandom;
                1: src_b_i = -src_a_i;
                2: src_b_i = src_a_i;
                default: src_b_i = 32'($urandom_range(0, 15));
            endcase
            #1;
            exp_ready = (!exp_valid || ready_i) && !flush_i;
            checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, ready_o, exp_ready); end
            if (flush_i) begin
                exp_valid = 1'b0;
            end else begin
                if (exp_valid && ready_i) exp_valid = 1'b0;
                if (valid_i && exp_ready) begin
                    ref_op(ALUOp_i, funct_i, src_a_i, src_b_i, r_res, r_ctrl, r_ill);
                    exp_valid = 1'b1; exp_res = r_res; exp_ctrl = r_ctrl; exp_ill = r_ill;
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

`ifdef ALU_EXEC_MUL_EN
    task automatic start_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        valid_i = 1'b1; ALUOp_i = 2'd3; funct_i = 6'h18; src_a_i = a; src_b_i = b;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mul_accept_ready: got %b want 1", ready_o); end
        tick();
        valid_i = 1'b1; funct_i = 6'h20; src_a_i = 32'd1; src_b_i = 32'd1;
    endtask

    task automatic test_mul;
        idle_inputs();
        start_mul(32'd7, 32'd6);
        for (int k = 1; k <= 32; k++) begin
            checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++; $display("FAIL mul_busy[%0d]: got rdy=%b v=%b want 0 0", k, ready_o, valid_o); end
            tick();
        end
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || result_o !== 32'd42 || ctrl_o !== 3'b011 || illegal_o !== 1'b0 || zero_o !== 1'b0) begin
            errors++; $display("FAIL mul_result: got v=%b r=%h c=%b i=%b want v=1 r=2a c=011 i=0", valid_o, result_o, ctrl_o, illegal_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mul_drain: got %b want 0", valid_o); end
    endtask

    task automatic test_mul_stall;
        idle_inputs();
        ready_i = 1'b0;
        start_mul(32'h00010000, 32'h00010000);
        valid_i = 1'b0;
        repeat (32) tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (valid_o !== 1'b1 || result_o !== 32'd0 || zero_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++; $display("FAIL mul_stall[%0d]: got v=%b r=%h z=%b rdy=%b want 1 0 1 0", k, valid_o, result_o, zero_o, ready_o); end
            tick();
        end
        ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mul_stall_drain: got %b want 0", valid_o); end
    endtask

    task automatic test_mul_abort;
        logic seen;
        idle_inputs();
        start_mul(32'd3, 32'd5);
        valid_i = 1'b0;
        repeat (10) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_mul: got v=%b rdy=%b want 0 1", valid_o, ready_o); end
        seen = 1'b0;
        repeat (40) begin tick(); if (valid_o !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_emit: got %b want 0", seen); end
        start_mul(32'd3, 32'd5);
        valid_i = 1'b0;
        repeat (5) tick();
        rst_n_i = 1'b0;
        #2;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", ready_o); end
        rst_n_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin tick(); if (valid_o !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_emit: got %b want 0", seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
`ifdef ALU_EXEC_MUL_EN
        test_mul();
        test_mul_stall();
        test_mul_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
